uart_tx_fifo: RTL

- Transmit-side buffer that sits directly upstream of the UART transmitter.
- Accepts bytes from a host write port into a synchronous FIFO.
- Launches them one at a time into the transmitter using the transmitter's tx_start/tx_data/tx_busy/tx_done handshake.
- Decouples host bursts from the serial bit rate; no byte is sent until the previous frame's tx_done.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_tx_fifo_if.sv | 40 ++++
 rtl/uart_sync_fifo.sv | 79 +++++++
 rtl/uart_tx_fifo.sv | 90 +++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions.
//   UART_DATA_W  : serial payload width (one byte per frame)
//   CLKS_PER_BIT : default bit period in clocks for transmitter instances
//   tx_state_t   : launch FSM states of uart_tx_fifo
package uart_pkg;

  localparam int UART_DATA_W  = 8;
  localparam int CLKS_PER_BIT = 5208;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2
  } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Bundle between uart_tx_fifo and its environment (host write port on one
// side, UART transmitter handshake on the other).
//   slave  : the buffer itself
//   master : host + transmitter, which drive writes, flush, tx_busy, tx_done
//   state  : launch FSM state, exported for observation
//
// Handshake: the buffer pulses tx_start for one cycle with tx_data valid in
// that cycle; the transmitter raises tx_busy the next cycle, holds it for the
// frame, and pulses tx_done once when the frame is on the line. A new
// tx_start is only issued from IDLE with tx_busy low.
interface uart_tx_fifo_if
  import uart_pkg::*;
#(
  parameter int ADDR_W = 4
);

  logic                   wr_en;
  logic [UART_DATA_W-1:0] wr_data;
  logic                   flush;
  logic                   full;
  logic                   empty;
  logic [ADDR_W:0]        count;
  logic                   overflow;
  logic                   tx_start;
  logic [UART_DATA_W-1:0] tx_data;
  logic                   tx_busy;
  logic                   tx_done;
  tx_state_t              state;

  modport slave (
    input  wr_en, wr_data, flush, tx_busy, tx_done,
    output full, empty, count, overflow, tx_start, tx_data, state
  );

  modport master (
    output wr_en, wr_data, flush, tx_busy, tx_done,
    input  full, empty, count, overflow, tx_start, tx_data, state
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous byte FIFO with first-word-fall-through read data.
//   wr_en/wr_data : push, ignored while full or flushing
//   rd_en/rd_data : pop; rd_data always shows the head entry
//   flush         : clears pointers and occupancy, dominates push/pop
//   full/empty/count : registered occupancy flags, mutually consistent
// Storage is not reset; only pointers and occupancy are.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [UART_DATA_W-1:0] wr_data,
  input  logic                   rd_en,
  output logic [UART_DATA_W-1:0] rd_data,
  input  logic                   flush,
  output logic                   full,
  output logic                   empty,
  output logic [ADDR_W:0]        count
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [UART_DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]      wr_ptr;
  logic [ADDR_W-1:0]      rd_ptr;
  logic [ADDR_W:0]        count_nxt;
  logic                   wr_acc;
  logic                   rd_acc;

  // No bypass: a push into a full FIFO is dropped even if a pop happens in
  // the same cycle, because acceptance looks at the pre-edge full flag.
  assign wr_acc  = wr_en && !full  && !flush;
  assign rd_acc  = rd_en && !empty && !flush;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (flush) begin
      count_nxt = '0;
    end else if (wr_acc && !rd_acc) begin
      count_nxt = count + (ADDR_W+1)'(1);
    end else if (!wr_acc && rd_acc) begin
      count_nxt = count - (ADDR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_acc) wr_ptr <= wr_ptr + ADDR_W'(1);
        if (rd_acc) rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      count <= count_nxt;
      full  <= (count_nxt == DEPTH_C);
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit buffer in front of a UART transmitter. Host bytes are queued in a
// FIFO and launched one frame at a time over the tx_start/tx_busy/tx_done
// handshake.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : uart_tx_fifo_if slave (write port, flush, occupancy flags,
//              overflow pulse, transmitter handshake, FSM state)
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_fifo_if.slave bus
);

  tx_state_t              state;
  tx_state_t              state_nxt;
  logic                   pop;
  logic                   tx_start_r;
  logic [UART_DATA_W-1:0] tx_data_r;
  logic                   overflow_r;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [ADDR_W:0]        fifo_count;
  logic [UART_DATA_W-1:0] head;

  uart_sync_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (bus.wr_en),
    .wr_data (bus.wr_data),
    .rd_en   (pop),
    .rd_data (head),
    .flush   (bus.flush),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // The FIFO head is consumed only on the IDLE->LAUNCH transition. A flush
  // in the same cycle suppresses the launch so no flushed byte escapes.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && !bus.tx_busy && !bus.flush) begin
          pop       = 1'b1;
          state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        if (bus.tx_busy) state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (bus.tx_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tx_start_r <= 1'b0;
      tx_data_r  <= '0;
      overflow_r <= 1'b0;
    end else begin
      state      <= state_nxt;
      tx_start_r <= pop;
      if (pop) tx_data_r <= head;
      // A flushed write is dropped silently, not counted as overflow.
      overflow_r <= bus.wr_en && fifo_full && !bus.flush;
    end
  end

  assign bus.full     = fifo_full;
  assign bus.empty    = fifo_empty;
  assign bus.count    = fifo_count;
  assign bus.overflow = overflow_r;
  assign bus.tx_start = tx_start_r;
  assign bus.tx_data  = tx_data_r;
  assign bus.state    = state;

endmodule
